pes_sysarray_wb: RTL and testbench

Write-back stage directly downstream of `pes_sysarray`. Captures one `mul_outcome` row of ARRAY_SIZE signed accumulators, requantizes each element to signed 8-bit, and packs the bytes into SRAM words. It then writes the row to the output SRAM over consecutive cycles and tracks rows per matrix. It signals `wb_done` when a full ARRAY_SIZE-row matrix has been written.

---
 rtl/pes_sysarray_pkg.sv | 27 ++
 rtl/pes_wb_quant.sv | 38 +++
 rtl/pes_sysarray_wb.sv | 127 ++++++++++++
 tb/tb_pes_sysarray_wb.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pes_sysarray_pkg.sv
// Shared types and sizing helpers for the pes_sysarray write-back stage.
// Defining PES_WB_RELU_EN narrows the requantizer saturation floor to zero.
package pes_sysarray_pkg;

    typedef enum logic [1:0] {
        IDLE,
        QUANT,
        WRITE,
        DONE
    } wb_state_t;

    function automatic int acc_w(input int data_width);
        return 2 * data_width + 5;
    endfunction

    function automatic int wpr(input int array_size, input int data_width, input int sram_width);
        return array_size * data_width / sram_width;
    endfunction

    localparam int SAT_MAX = 127;
`ifdef PES_WB_RELU_EN
    localparam int SAT_MIN = 0;
`else
    localparam int SAT_MIN = -128;
`endif

endpackage

// File: rtl/pes_wb_quant.sv
// Combinational requantizer: round-half-up arithmetic right shift of one
// accumulator, then saturation to the output byte range.
module pes_wb_quant
    import pes_sysarray_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_W      = acc_w(DATA_WIDTH)
) (
    input  logic signed [ACC_W-1:0]      acc,
    input  logic        [4:0]            shift,
    output logic        [DATA_WIDTH-1:0] q
);

    localparam logic signed [ACC_W:0] ONE = 1;

    logic signed [ACC_W:0] acc_ext;
    logic signed [ACC_W:0] rounded;
    logic signed [ACC_W:0] shifted;

    // One guard bit keeps acc + half-LSB from overflowing at the positive extreme.
    always_comb begin
        acc_ext = {acc[ACC_W-1], acc};
        if (shift == 5'd0) begin
            rounded = acc_ext;
        end else begin
            rounded = acc_ext + (ONE <<< (shift - 5'd1));
        end
        shifted = rounded >>> shift;
        if (shifted > SAT_MAX) begin
            q = DATA_WIDTH'(SAT_MAX);
        end else if (shifted < SAT_MIN) begin
            q = DATA_WIDTH'(SAT_MIN);
        end else begin
            q = shifted[DATA_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/pes_sysarray_wb.sv
// Write-back stage after pes_sysarray: captures an accumulator row, requantizes it
// to bytes and streams the packed words into the output SRAM. Option: PES_WB_RELU_EN.
module pes_sysarray_wb
    import pes_sysarray_pkg::*;
#(
    parameter  int ARRAY_SIZE      = 8,
    parameter  int DATA_WIDTH      = 8,
    parameter  int SRAM_DATA_WIDTH = 32,
    parameter  int ADDR_WIDTH      = 10,
    localparam int ACC_W           = acc_w(DATA_WIDTH)
) (
    input  logic                              clk,
    input  logic                              srstn,
    input  logic                              wb_clear,
    input  logic                              row_valid,
    output logic                              row_ready,
    input  logic signed [ARRAY_SIZE*ACC_W-1:0] mul_outcome,
    input  logic [4:0]                        shift_amt,
    input  logic [5:0]                        matrix_index,
    output logic                              sram_wen,
    output logic [ADDR_WIDTH-1:0]             sram_waddr,
    output logic [SRAM_DATA_WIDTH-1:0]        sram_wdata,
    output logic                              wb_done
);

    localparam int WPR = wpr(ARRAY_SIZE, DATA_WIDTH, SRAM_DATA_WIDTH);
    localparam int WIW = (WPR > 1) ? $clog2(WPR) : 1;
    localparam int RCW = $clog2(ARRAY_SIZE + 1);

    wb_state_t                         state;
    logic [RCW-1:0]                    row_cnt;
    logic [WIW-1:0]                    word_idx;
    logic [5:0]                        mat_q;
    logic [ARRAY_SIZE*ACC_W-1:0]       acc_q;
    logic [4:0]                        shift_q;
    logic [SRAM_DATA_WIDTH-1:0]        words_q [WPR];
    logic [ARRAY_SIZE*DATA_WIDTH-1:0]  packed_row;
    logic [ADDR_WIDTH-1:0]             row_base;

    for (genvar i = 0; i < ARRAY_SIZE; i++) begin : g_quant
        pes_wb_quant #(
            .DATA_WIDTH(DATA_WIDTH),
            .ACC_W     (ACC_W)
        ) u_quant (
            .acc  (acc_q[i*ACC_W +: ACC_W]),
            .shift(shift_q),
            .q    (packed_row[i*DATA_WIDTH +: DATA_WIDTH])
        );
    end

    // Arithmetic in ADDR_WIDTH bits gives the modulo wrap of the address space for free.
    assign row_base = ADDR_WIDTH'(mat_q) * ADDR_WIDTH'(ARRAY_SIZE * WPR)
                    + ADDR_WIDTH'(row_cnt) * ADDR_WIDTH'(WPR);

    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            state      <= IDLE;
            row_cnt    <= '0;
            word_idx   <= '0;
            mat_q      <= '0;
            acc_q      <= '0;
            shift_q    <= '0;
            for (int w = 0; w < WPR; w++) words_q[w] <= '0;
            row_ready  <= 1'b1;
            sram_wen   <= 1'b0;
            sram_waddr <= '0;
            sram_wdata <= '0;
            wb_done    <= 1'b0;
        end else if (wb_clear) begin
            state     <= IDLE;
            row_cnt   <= '0;
            word_idx  <= '0;
            row_ready <= 1'b1;
            sram_wen  <= 1'b0;
            wb_done   <= 1'b0;
        end else begin
            sram_wen <= 1'b0;
            wb_done  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (row_valid) begin
                        acc_q     <= mul_outcome;
                        shift_q   <= shift_amt;
                        row_ready <= 1'b0;
                        state     <= QUANT;
                        if (row_cnt == '0) mat_q <= matrix_index;
                    end
                end
                // Word 0 leaves straight from the requantizers while the row is registered.
                QUANT: begin
                    for (int w = 0; w < WPR; w++) begin
                        words_q[w] <= packed_row[w*SRAM_DATA_WIDTH +: SRAM_DATA_WIDTH];
                    end
                    word_idx   <= '0;
                    sram_wen   <= 1'b1;
                    sram_waddr <= row_base;
                    sram_wdata <= packed_row[SRAM_DATA_WIDTH-1:0];
                    state      <= WRITE;
                end
                WRITE: begin
                    if (word_idx == WIW'(WPR - 1)) begin
                        row_cnt <= row_cnt + RCW'(1);
                        if (row_cnt == RCW'(ARRAY_SIZE - 1)) begin
                            wb_done <= 1'b1;
                            state   <= DONE;
                        end else begin
                            row_ready <= 1'b1;
                            state     <= IDLE;
                        end
                    end else begin
                        word_idx   <= word_idx + WIW'(1);
                        sram_wen   <= 1'b1;
                        sram_waddr <= sram_waddr + ADDR_WIDTH'(1);
                        sram_wdata <= words_q[word_idx + WIW'(1)];
                    end
                end
                DONE: begin
                    row_cnt   <= '0;
                    row_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pes_sysarray_wb.sv
// Randomized bench for pes_sysarray_wb: an event-schedule reference model predicts
// every SRAM write, wb_done pulse and row_ready level cycle by cycle.
`timescale 1ns/1ps
module tb_pes_sysarray_wb;

    localparam int AS    = 8;
    localparam int DW    = 8;
    localparam int SW    = 32;
    localparam int AW    = 10;
    localparam int ACC_W = 2 * DW + 5;
    localparam int WPR   = AS * DW / SW;
    localparam int EPW   = SW / DW;
    localparam int QMAX  = 127;
`ifdef PES_WB_RELU_EN
    localparam int QMIN  = 0;
`else
    localparam int QMIN  = -128;
`endif

    logic                        clk = 1'b0;
    logic                        srstn = 1'b0;
    logic                        wb_clear = 1'b0;
    logic                        row_valid = 1'b0;
    logic                        row_ready;
    logic signed [AS*ACC_W-1:0]  mul_outcome = '0;
    logic [4:0]                  shift_amt = '0;
    logic [5:0]                  matrix_index = '0;
    logic                        sram_wen;
    logic [AW-1:0]               sram_waddr;
    logic [SW-1:0]               sram_wdata;
    logic                        wb_done;

    pes_sysarray_wb dut (
        .clk         (clk),
        .srstn       (srstn),
        .wb_clear    (wb_clear),
        .row_valid   (row_valid),
        .row_ready   (row_ready),
        .mul_outcome (mul_outcome),
        .shift_amt   (shift_amt),
        .matrix_index(matrix_index),
        .sram_wen    (sram_wen),
        .sram_waddr  (sram_waddr),
        .sram_wdata  (sram_wdata),
        .wb_done     (wb_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int ready_after = 0;
    int m_row = 0;
    int m_mat = 0;
    bit captured = 1'b0;
    int elems [AS];

    // Expected events keyed by the edge count after which they are visible.
    bit            exp_wen  [int];
    logic [AW-1:0] exp_addr [int];
    logic [SW-1:0] exp_data [int];
    bit            exp_done [int];
    logic [AW-1:0] last_addr = '0;
    logic [SW-1:0] last_data = '0;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, got, want);
        end
    endtask

    function automatic logic [7:0] ref_quant(input int acc, input int s);
        longint q;
        if (s == 0) q = longint'(acc);
        else        q = (longint'(acc) + (longint'(1) << (s - 1))) >>> s;
        if (q > QMAX) q = QMAX;
        if (q < QMIN) q = QMIN;
        return 8'(q);
    endfunction

    task automatic drop_from(input int k);
        for (int t = k; t < k + 8; t++) begin
            if (exp_wen.exists(t))  exp_wen.delete(t);
            if (exp_addr.exists(t)) exp_addr.delete(t);
            if (exp_data.exists(t)) exp_data.delete(t);
            if (exp_done.exists(t)) exp_done.delete(t);
        end
    endtask

    task automatic model_edge();
        int k = cyc;
        logic [SW-1:0] word;
        captured = 1'b0;
        if (wb_clear) begin
            drop_from(k);
            m_row = 0;
            ready_after = k;
        end else if (row_valid && (k - 1 >= ready_after)) begin
            captured = 1'b1;
            if (m_row == 0) m_mat = matrix_index;
            for (int w = 0; w < WPR; w++) begin
                word = '0;
                for (int b = 0; b < EPW; b++) begin
                    word[b*DW +: DW] = ref_quant(elems[w*EPW + b], shift_amt);
                end
                exp_wen[k + 1 + w]  = 1'b1;
                exp_addr[k + 1 + w] = AW'((m_mat * AS * WPR + m_row * WPR + w) % (1 << AW));
                exp_data[k + 1 + w] = word;
            end
            if (m_row == AS - 1) begin
                exp_done[k + 1 + WPR] = 1'b1;
                ready_after = k + 2 + WPR;
                m_row = 0;
            end else begin
                ready_after = k + 1 + WPR;
                m_row++;
            end
        end
    endtask

    task automatic check_cycle();
        int k = cyc;
        checkOutput("sram_wen", sram_wen, exp_wen.exists(k));
        if (exp_wen.exists(k)) begin
            last_addr = exp_addr[k];
            last_data = exp_data[k];
        end
        checkOutput("sram_waddr", sram_waddr, last_addr);
        checkOutput("sram_wdata", sram_wdata, last_data);
        checkOutput("wb_done", wb_done, exp_done.exists(k));
        checkOutput("row_ready", row_ready, k >= ready_after);
    endtask

    task automatic applyStimulus(input bit valid, input bit clr, input int mi, input int sh);
        @(negedge clk);
        row_valid    = valid;
        wb_clear     = clr;
        matrix_index = 6'(mi);
        shift_amt    = 5'(sh);
        for (int i = 0; i < AS; i++) mul_outcome[i*ACC_W +: ACC_W] = ACC_W'(elems[i]);
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
        check_cycle();
    endtask

    task automatic send_row(input int mi, input int sh);
        int n = 0;
        do begin
            applyStimulus(1'b1, 1'b0, mi, sh);
            n++;
        end while (!captured && n < 12);
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b0, 1'b0, matrix_index, shift_amt);
    endtask

    task automatic randomize_row();
        for (int i = 0; i < AS; i++) begin
            if ($urandom_range(0, 1) == 0)
                elems[i] = int'($urandom_range(0, (1 << ACC_W) - 1)) - (1 << (ACC_W - 1));
            else
                elems[i] = int'($urandom_range(0, 600)) - 300;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        checkOutput({tag, "_row_ready"}, row_ready, 1);
        checkOutput({tag, "_sram_wen"}, sram_wen, 0);
        checkOutput({tag, "_sram_waddr"}, sram_waddr, 0);
        checkOutput({tag, "_sram_wdata"}, sram_wdata, 0);
        checkOutput({tag, "_wb_done"}, wb_done, 0);
    endtask

    initial begin
        for (int i = 0; i < AS; i++) elems[i] = 0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        srstn = 1'b1;

        for (int i = 0; i < AS; i++) elems[i] = i + 1;
        send_row(0, 0);
        idle(4);

        elems = '{24, 23, -24, 5000, -5000, 0, 8, -8};
        send_row(0, 4);
        idle(4);

        applyStimulus(1'b1, 1'b1, 0, 0);
        idle(2);

        for (int r = 0; r < AS; r++) begin
            randomize_row();
            send_row((r == 0) ? 3 : 5, $urandom_range(0, ACC_W - 1));
        end
        idle(3);

        for (int r = 0; r < 3; r++) begin
            randomize_row();
            send_row(7, $urandom_range(0, ACC_W - 1));
        end
        applyStimulus(1'b0, 1'b0, 7, 0);
        applyStimulus(1'b0, 1'b1, 7, 0);
        idle(2);
        randomize_row();
        send_row(9, $urandom_range(0, ACC_W - 1));
        idle(4);

        randomize_row();
        send_row(11, 3);
        @(negedge clk);
        row_valid = 1'b0;
        srstn = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        drop_from(cyc);
        m_row = 0;
        ready_after = cyc;
        last_addr = '0;
        last_data = '0;
        @(posedge clk);
        cyc++;
        #1;
        check_cycle();
        srstn = 1'b1;
        idle(4);

        for (int r = 0; r < AS; r++) begin
            randomize_row();
            send_row(63, $urandom_range(0, ACC_W - 1));
        end
        randomize_row();
        send_row(0, $urandom_range(0, ACC_W - 1));
        idle(5);

        repeat (24) begin
            randomize_row();
            if ($urandom_range(0, 9) == 0) applyStimulus(1'b1, 1'b1, $urandom_range(0, 63), 0);
            send_row($urandom_range(0, 63), $urandom_range(0, ACC_W - 1));
            if ($urandom_range(0, 7) == 0) begin
                idle($urandom_range(0, 2));
                applyStimulus(1'b0, 1'b1, 0, 0);
            end
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        end
        idle(6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
